// File: rtl/kp_scan_pkg.sv
// Shared types, sizes and scan-result helpers for the kp_scan keypad scanner.
package kp_scan_pkg;

  localparam int unsigned KEY_W    = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned ROW_W    = $clog2(NUM_ROWS);
  localparam int unsigned COL_W    = $clog2(NUM_COLS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } scan_res_e;

  // Classify one row sample; 'low' has a 1 for every column pulled low.
  function automatic scan_res_e row_result(input logic [NUM_COLS-1:0] low);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      n = n + 32'(low[i]);
    end
    if (n == 0) return RES_NONE;
    if (n == 1) return RES_SINGLE;
    return RES_MULTI;
  endfunction

  function automatic logic [COL_W-1:0] first_col(input logic [NUM_COLS-1:0] low);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_COLS; i > 0; i--) begin
      if (low[i-1]) idx = COL_W'(i - 1);
    end
    return idx;
  endfunction

  // Two single hits, or any multi, make the combined scan a multi.
  function automatic scan_res_e merge_res(input scan_res_e a, input scan_res_e b);
    if (a == RES_NONE) return b;
    if (b == RES_NONE) return a;
    return RES_MULTI;
  endfunction

endpackage

// File: rtl/kp_col_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad column lines.
module kp_col_sync
  import kp_scan_pkg::*;
#(
  parameter int unsigned W = NUM_COLS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/kp_scan.sv
// 4x4 keypad scanner: row divider, full-scan classification, debounce FSM and
// key handshake. Define KP_SCAN_REPEAT_EN to add auto-repeat while a key is held.
module kp_scan
  import kp_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned DEB_SCANS = 3,
  parameter int unsigned REP_DELAY = 40,
  parameter int unsigned REP_RATE  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overflow,
  output logic [7:0] key_hist
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = $clog2(DEB_SCANS + 1);

  if (SCAN_DIV < 4 || DEB_SCANS < 2 || REP_DELAY < 1 || REP_RATE < 1) begin : g_param_check
    $error("kp_scan: illegal parameter value");
  end

  logic [NUM_COLS-1:0] col_s;

  kp_col_sync #(.W(NUM_COLS)) u_col_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (col),
    .q_o   (col_s)
  );

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  scan_res_e        acc_res_q, acc_res_d;
  logic [KEY_W-1:0] acc_code_q, acc_code_d;
  kp_state_e        state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       hist_q, hist_d;

  logic             wrap;
  logic             scan_done;
  scan_res_e        base_res;
  scan_res_e        scan_res;
  logic [KEY_W-1:0] scan_code;
  logic [DEB_W-1:0] deb_inc;
  logic             emit;
  logic             rep_emit;
  logic             emit_any;

  assign wrap      = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign scan_done = wrap && (row_idx_q == ROW_W'(NUM_ROWS - 1));
  assign deb_inc   = deb_q + DEB_W'(1);

  // Row 0 starts a fresh scan; row 3's result is merged combinationally so
  // the FSM sees the complete scan at the same edge that samples it.
  assign base_res  = (row_idx_q == '0) ? RES_NONE : acc_res_q;
  assign scan_res  = merge_res(base_res, row_result(~col_s));
  assign scan_code = (base_res == RES_NONE) ? {row_idx_q, first_col(~col_s)} : acc_code_q;

  always_comb begin
    cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);
    row_idx_d  = row_idx_q;
    acc_res_d  = acc_res_q;
    acc_code_d = acc_code_q;
    if (wrap) begin
      row_idx_d  = row_idx_q + ROW_W'(1);
      acc_res_d  = scan_res;
      acc_code_d = scan_code;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    cand_d  = cand_q;
    emit    = 1'b0;
    if (scan_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_res == RES_SINGLE) begin
            state_d = ST_DEBOUNCE;
            cand_d  = scan_code;
            deb_d   = DEB_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (scan_res == RES_SINGLE && scan_code == cand_q) begin
            if (deb_inc == DEB_W'(DEB_SCANS)) begin
              emit    = 1'b1;
              state_d = ST_PRESSED;
              deb_d   = '0;
            end else begin
              deb_d = deb_inc;
            end
          end else if (scan_res == RES_SINGLE) begin
            cand_d = scan_code;
            deb_d  = DEB_W'(1);
          end else begin
            state_d = ST_IDLE;
            deb_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (scan_res == RES_NONE) begin
            state_d = ST_RELEASE;
            deb_d   = DEB_W'(1);
          end
        end
        ST_RELEASE: begin
          if (scan_res == RES_NONE) begin
            if (deb_inc == DEB_W'(DEB_SCANS)) begin
              state_d = ST_IDLE;
              deb_d   = '0;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            state_d = ST_PRESSED;
            deb_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          deb_d   = '0;
        end
      endcase
    end
  end

`ifdef KP_SCAN_REPEAT_EN
  localparam int unsigned REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] rep_inc;
  logic             rep_phase_q, rep_phase_d;

  assign rep_inc = rep_q + REP_W'(1);

  // rep_phase_q selects the initial delay versus the steady repeat interval.
  always_comb begin
    rep_d       = rep_q;
    rep_phase_d = rep_phase_q;
    rep_emit    = 1'b0;
    if (scan_done) begin
      if (state_q == ST_PRESSED && scan_res == RES_SINGLE && scan_code == cand_q) begin
        if (rep_inc == (rep_phase_q ? REP_W'(REP_RATE) : REP_W'(REP_DELAY))) begin
          rep_emit    = 1'b1;
          rep_d       = '0;
          rep_phase_d = 1'b1;
        end else begin
          rep_d = rep_inc;
        end
      end else begin
        rep_d       = '0;
        rep_phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q       <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_emit = 1'b0;
`endif

  assign emit_any = emit | rep_emit;

  // A key arriving while the previous one is unacknowledged is dropped,
  // unless the acknowledge lands on the very same edge.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    hist_d  = hist_q;
    ovf_d   = ovf_q;
    if (valid_q && key_ack) valid_d = 1'b0;
    if (emit_any) begin
      if (!valid_q || key_ack) begin
        code_d  = cand_q;
        hist_d  = {hist_q[3:0], cand_q};
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      row_idx_q  <= '0;
      acc_res_q  <= RES_NONE;
      acc_code_q <= '0;
      state_q    <= ST_IDLE;
      deb_q      <= '0;
      cand_q     <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      hist_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      row_idx_q  <= row_idx_d;
      acc_res_q  <= acc_res_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      deb_q      <= deb_d;
      cand_q     <= cand_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      hist_q     <= hist_d;
    end
  end

  // Rows release immediately with reset so none is driven while it is held.
  assign row       = rst ? '1 : ~(4'b0001 << row_idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);
  assign overflow  = ovf_q;
  assign key_hist  = hist_q;

endmodule

// File: doc/kp_scan.md
KP_SCAN -- requirements
Module: kp_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles each row is driven; minimum 4.
REQ-002 Parameter DEB_SCANS, default 3, consecutive identical full scans needed to accept a press or release; minimum 2.
REQ-003 Parameters REP_DELAY, default 40, and REP_RATE, default 8, are auto-repeat intervals in full scans; they are used only when KP_SCAN_REPEAT_EN is defined.
REQ-004 Port clk, input, 1 bit: single clock; all logic SHALL be rising-edge clocked.
REQ-005 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port col, input, 4 bits: keypad columns, active-low, externally pulled up, asynchronous to clk.
REQ-007 Port row, output, 4 bits: keypad row drive, active-low, one row low at a time.
REQ-008 Port key_code, output, 4 bits: accepted key, equal to row_index*4 + col_index.
REQ-009 Port key_valid, output, 1 bit: key_code holds an unacknowledged key.
REQ-010 Port key_ack, input, 1 bit: consumer acknowledge.
REQ-011 Port key_down, output, 1 bit: high while a debounced key is held.
REQ-012 Port overflow, output, 1 bit: sticky flag, set when a key is dropped.
REQ-013 Port key_hist, output, 8 bits: the last two accepted codes, newest in [3:0]; intended for direct use as a display byte.

Function
REQ-014 col SHALL pass through a 2-flop synchronizer before any use.
REQ-015 A divider counter cnt SHALL count 0..SCAN_DIV-1; the row index SHALL advance 0→1→2→3→0 when cnt wraps; row SHALL be low only at bit [row index].
REQ-016 Synchronized columns SHALL be sampled when cnt==SCAN_DIV-1, for the current row.
REQ-017 After the row 3 sample, the full-scan result SHALL be NONE (no low columns), SINGLE(code) (exactly one low bit across all rows) or MULTI; MULTI SHALL be treated as NONE in IDLE and DEBOUNCE, and as "held" in PRESSED.
REQ-018 The FSM SHALL step exactly once per full scan, with states IDLE, DEBOUNCE, PRESSED and RELEASE.
REQ-019 IDLE: SINGLE(k) → DEBOUNCE, with cand=k and deb=1; otherwise stay in IDLE.
REQ-020 DEBOUNCE: SINGLE(cand) → deb+1; when deb reaches DEB_SCANS, emit cand and go to PRESSED. SINGLE(other) → restart with the new cand and deb=1. NONE → IDLE.
REQ-021 PRESSED: NONE → RELEASE with deb=1; any other result → stay in PRESSED, with no new emission (except auto-repeat).
REQ-022 RELEASE: NONE → deb+1; when deb reaches DEB_SCANS → IDLE. Any key → PRESSED, with no emission.
REQ-023 key_down SHALL be high in the PRESSED and RELEASE states.
REQ-024 Emission is registered at the same edge as the FSM step. key_code and key_hist={key_hist[3:0],code} SHALL be loaded, and key_valid SHALL be set.
REQ-025 key_ack sampled high while key_valid is high SHALL clear key_valid on the next cycle; key_ack while key_valid is low SHALL be ignored.
REQ-026 If an emission occurs while key_valid is high and key_ack is low: the new key SHALL be dropped (key_code and key_hist unchanged) and overflow SHALL be set.
REQ-027 If an emission and key_ack occur in the same cycle: the new key SHALL be loaded and key_valid SHALL stay high, with no overflow.

Reset
REQ-028 While rst is high, the block SHALL hold: row=4'b1111, cnt=0, row index=0, state=IDLE, deb=0, synchronizer flops=4'b1111, key_code=0, key_valid=0, key_down=0, overflow=0, key_hist=0.
REQ-029 On the first cycle with rst low, row SHALL be 4'b1110.
REQ-030 rst asserted mid-debounce or mid-handshake SHALL abort with no emission; a pending key SHALL be lost.
REQ-031 overflow SHALL clear only on reset.

Configuration
REQ-032 With KP_SCAN_REPEAT_EN defined, a key continuously SINGLE(cand) in PRESSED SHALL re-emit after REP_DELAY full scans and then every REP_RATE scans; MULTI or NONE SHALL reset the repeat counter.
REQ-033 With KP_SCAN_REPEAT_EN undefined, there SHALL be exactly one emission per press, and no repeat counter logic SHALL be synthesized.

Structure
REQ-034 Package kp_scan_pkg SHALL hold the FSM state enum, the scan-result enum (NONE/SINGLE/MULTI), KEY_W=4 and NUM_ROWS=4.
REQ-035 Sub-module kp_col_sync (4-bit 2-flop synchronizer) SHALL be instantiated once; the FSM and the divider SHALL stay in kp_scan.

Verification (SCAN_DIV=4, DEB_SCANS=3, 16-cycle full scan, cycle 0 = first cycle with rst low)
REQ-036 Row 2 col 1 held low from before reset release → key_valid rises at cycle 48, key_code=9, key_hist=8'h09, key_down=1.
REQ-037 Key 9 is bounced: present for two scans, absent for one, present for three → exactly one emission, after the final third scan.
REQ-038 Key 5 is accepted and not acked, then released and key 6 is pressed → overflow=1, key_code stays 5; key_ack then gives key_valid=0 on the next cycle.
REQ-039 Keys 3 and 12 are held together → no emission, key_down=0; releasing 12 → key 3 is emitted after 3 scans.
REQ-040 With KP_SCAN_REPEAT_EN, REP_DELAY=4 and REP_RATE=2, key 0 is held and acked each time → emissions at scans 3, 7, 9 and 11; without the macro, only the scan 3 emission occurs.
REQ-041 rst is pulsed at cycle 40 during DEBOUNCE → no emission, and all outputs return to their reset values.
